vinc_port_sched: RTL and testbench

//   Shares the single read port (a) and single write port (c) of the inc register file between two

---
 rtl/vinc_port_sched.sv | 138 +++++++++++++
 tb/tb_vinc_port_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vinc_port_sched.sv
// vinc_port_sched: shares the inc register file read port (a) and write
// port (c) between two readers and two writers, with forwarding and inc0=0.
module vinc_port_sched #(
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 8,
  parameter int LOG2NUMREGS  = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rq0_valid,
  input  logic [LOG2NUMREGS-1:0] rq0_reg,
  output logic                   rq0_ready,
  input  logic                   rq1_valid,
  input  logic [LOG2NUMREGS-1:0] rq1_reg,
  output logic                   rq1_ready,
  output logic                   rs0_valid,
  output logic [WIDTH-1:0]       rs0_data,
  output logic                   rs1_valid,
  output logic [WIDTH-1:0]       rs1_data,
  input  logic                   wq0_valid,
  input  logic [LOG2NUMREGS-1:0] wq0_reg,
  input  logic [WIDTH-1:0]       wq0_data,
  output logic                   wq0_ready,
  input  logic                   wq1_valid,
  input  logic [LOG2NUMREGS-1:0] wq1_reg,
  input  logic [WIDTH-1:0]       wq1_data,
  output logic                   wq1_ready,
  output logic [LOG2NUMREGS-1:0] rf_a_reg,
  output logic                   rf_a_en,
  input  logic [WIDTH-1:0]       rf_a_readdataout,
  output logic [LOG2NUMREGS-1:0] rf_c_reg,
  output logic [WIDTH-1:0]       rf_c_writedatain,
  output logic                   rf_c_we
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic                   rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]          starve_cnt_q, starve_cnt_d;
  logic                   pend_vld_q, pend_vld_d;
  logic                   pend_id_q, pend_id_d;
  logic [LOG2NUMREGS-1:0] pend_reg_q, pend_reg_d;
  logic                   fwd_hit_q, fwd_hit_d;
  logic [WIDTH-1:0]       fwd_data_q, fwd_data_d;
  logic [WIDTH-1:0]       rs0_hold_q, rs0_hold_d;
  logic [WIDTH-1:0]       rs1_hold_q, rs1_hold_d;

  logic                   rd_g0, rd_g1, rd_any;
  logic [LOG2NUMREGS-1:0] rd_reg;
  logic                   force_w1, wr_g0, wr_g1, wr_any;
  logic [LOG2NUMREGS-1:0] wr_reg;
  logic [WIDTH-1:0]       wr_data;
  logic [WIDTH-1:0]       resp_data;

  always_comb begin
    rd_g0    = rq0_valid & (~rq1_valid | ~rd_ptr_q);
    rd_g1    = rq1_valid & (~rq0_valid | rd_ptr_q);
    rd_any   = rd_g0 | rd_g1;
    rd_reg   = '0;
    if (rd_g1)      rd_reg = rq1_reg;
    else if (rd_g0) rd_reg = rq0_reg;
    rd_ptr_d = (rq0_valid & rq1_valid) ? ~rd_ptr_q : rd_ptr_q;

    // w1 wins outright once it has lost STARVE_LIMIT cycles in a row
    force_w1 = wq1_valid & (starve_cnt_q == SLIM);
    wr_g0    = wq0_valid & ~force_w1;
    wr_g1    = wq1_valid & ~wr_g0;
    wr_any   = wr_g0 | wr_g1;
    wr_reg   = '0;
    wr_data  = '0;
    if (wr_g1) begin
      wr_reg  = wq1_reg;
      wr_data = wq1_data;
    end else if (wr_g0) begin
      wr_reg  = wq0_reg;
      wr_data = wq0_data;
    end

    starve_cnt_d = starve_cnt_q;
    if (!wq1_valid || wr_g1)   starve_cnt_d = '0;
    else if (starve_cnt_q != SLIM) starve_cnt_d = starve_cnt_q + 1'b1;

    rq0_ready        = rd_g0;
    rq1_ready        = rd_g1;
    wq0_ready        = wr_g0;
    wq1_ready        = wr_g1;
    rf_a_en          = rd_any;
    rf_a_reg         = rd_reg;
    rf_c_reg         = wr_reg;
    rf_c_writedatain = wr_data;
    rf_c_we          = wr_any && (wr_reg != '0) && (int'(wr_reg) < NUMREGS);

    pend_vld_d = rd_any;
    pend_id_d  = rd_g1;
    pend_reg_d = rd_reg;
    // RAM returns old data on a same-address read/write; remember the new one
    fwd_hit_d  = rd_any & rf_c_we & (wr_reg == rd_reg);
    fwd_data_d = fwd_hit_d ? wr_data : fwd_data_q;

    resp_data = rf_a_readdataout;
    if (pend_reg_q == '0) resp_data = '0;
    else if (fwd_hit_q)   resp_data = fwd_data_q;

    rs0_valid  = pend_vld_q & ~pend_id_q;
    rs1_valid  = pend_vld_q & pend_id_q;
    rs0_data   = rs0_valid ? resp_data : rs0_hold_q;
    rs1_data   = rs1_valid ? resp_data : rs1_hold_q;
    rs0_hold_d = rs0_data;
    rs1_hold_d = rs1_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q     <= 1'b0;
      starve_cnt_q <= '0;
      pend_vld_q   <= 1'b0;
      pend_id_q    <= 1'b0;
      pend_reg_q   <= '0;
      fwd_hit_q    <= 1'b0;
      fwd_data_q   <= '0;
      rs0_hold_q   <= '0;
      rs1_hold_q   <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      pend_vld_q   <= pend_vld_d;
      pend_id_q    <= pend_id_d;
      pend_reg_q   <= pend_reg_d;
      fwd_hit_q    <= fwd_hit_d;
      fwd_data_q   <= fwd_data_d;
      rs0_hold_q   <= rs0_hold_d;
      rs1_hold_q   <= rs1_hold_d;
    end
  end

endmodule

// File: tb/tb_vinc_port_sched.sv
// tb_vinc_port_sched: vector table plus response scoreboard against a
// behavioural old-data register file.
module tb_vinc_port_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        rq0_valid, rq1_valid, rq0_ready, rq1_ready;
  logic [2:0]  rq0_reg, rq1_reg;
  logic        rs0_valid, rs1_valid;
  logic [31:0] rs0_data, rs1_data;
  logic        wq0_valid, wq1_valid, wq0_ready, wq1_ready;
  logic [2:0]  wq0_reg, wq1_reg;
  logic [31:0] wq0_data, wq1_data;
  logic [2:0]  rf_a_reg, rf_c_reg;
  logic        rf_a_en, rf_c_we;
  logic [31:0] rf_a_readdataout, rf_c_writedatain;

  vinc_port_sched dut (
    .clk(clk), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_reg(rq0_reg), .rq0_ready(rq0_ready),
    .rq1_valid(rq1_valid), .rq1_reg(rq1_reg), .rq1_ready(rq1_ready),
    .rs0_valid(rs0_valid), .rs0_data(rs0_data),
    .rs1_valid(rs1_valid), .rs1_data(rs1_data),
    .wq0_valid(wq0_valid), .wq0_reg(wq0_reg), .wq0_data(wq0_data),
    .wq0_ready(wq0_ready),
    .wq1_valid(wq1_valid), .wq1_reg(wq1_reg), .wq1_data(wq1_data),
    .wq1_ready(wq1_ready),
    .rf_a_reg(rf_a_reg), .rf_a_en(rf_a_en),
    .rf_a_readdataout(rf_a_readdataout),
    .rf_c_reg(rf_c_reg), .rf_c_writedatain(rf_c_writedatain),
    .rf_c_we(rf_c_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0v, r1v, w0v, w1v;
    logic [2:0]  r0r, r1r, w0r, w1r;
    logic [31:0] w0d, w1d;
    logic        er0, er1, ew0, ew1;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  logic [31:0] ram [8];
  logic [31:0] rd_q;
  logic [31:0] mdl [8];
  logic [31:0] last0, last1;
  sb_t         sb [$];
  vec_t        vt [$];
  vec_t        vt2 [$];

  // register file: registered read returning old data on collision
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) ram[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (rf_c_we) begin
      ram[rf_c_reg] <= rf_c_writedatain;
    end
    if (rf_a_en) rd_q <= ram[rf_a_reg];
  end
  assign rf_a_readdataout = rd_q;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc_cnt);
    end
  endtask

  function automatic vec_t V(int r0v, int r0r, int r1v, int r1r,
                             int w0v, int w0r, logic [31:0] w0d,
                             int w1v, int w1r, logic [31:0] w1d, int e);
    vec_t v;
    v.r0v = r0v[0]; v.r0r = r0r[2:0];
    v.r1v = r1v[0]; v.r1r = r1r[2:0];
    v.w0v = w0v[0]; v.w0r = w0r[2:0]; v.w0d = w0d;
    v.w1v = w1v[0]; v.w1r = w1r[2:0]; v.w1d = w1d;
    v.er0 = e[3]; v.er1 = e[2]; v.ew0 = e[1]; v.ew1 = e[0];
    return v;
  endfunction

  task automatic mdl_init();
    for (int i = 0; i < 8; i++) mdl[i] = 32'hBAD0_0000 | 32'(i);
  endtask

  task automatic idle_inputs();
    rq0_valid = 0; rq0_reg = 0; rq1_valid = 0; rq1_reg = 0;
    wq0_valid = 0; wq0_reg = 0; wq0_data = 0;
    wq1_valid = 0; wq1_reg = 0; wq1_data = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    logic [2:0]  rreg, wreg;
    logic [31:0] wdat, rexp;
    logic        rd, wr, we;
    rq0_valid = v.r0v; rq0_reg = v.r0r;
    rq1_valid = v.r1v; rq1_reg = v.r1r;
    wq0_valid = v.w0v; wq0_reg = v.w0r; wq0_data = v.w0d;
    wq1_valid = v.w1v; wq1_reg = v.w1r; wq1_data = v.w1d;
    @(negedge clk);
    chk("rq0_ready", 32'(rq0_ready), 32'(v.er0));
    chk("rq1_ready", 32'(rq1_ready), 32'(v.er1));
    chk("wq0_ready", 32'(wq0_ready), 32'(v.ew0));
    chk("wq1_ready", 32'(wq1_ready), 32'(v.ew1));
    rd   = v.er0 | v.er1;
    rreg = rd ? (v.er1 ? v.r1r : v.r0r) : 3'd0;
    wr   = v.ew0 | v.ew1;
    wreg = v.ew1 ? v.w1r : v.w0r;
    wdat = v.ew1 ? v.w1d : v.w0d;
    we   = wr && (wreg != 3'd0);
    chk("rf_a_en", 32'(rf_a_en), 32'(rd));
    chk("rf_a_reg", 32'(rf_a_reg), 32'(rreg));
    chk("rf_c_we", 32'(rf_c_we), 32'(we));
    if (wr) begin
      chk("rf_c_reg", 32'(rf_c_reg), 32'(wreg));
      chk("rf_c_data", rf_c_writedatain, wdat);
    end
    if (rd) begin
      if (rreg == 3'd0)              rexp = 32'h0;
      else if (we && wreg == rreg)   rexp = wdat;
      else                           rexp = mdl[rreg];
      sb.push_back('{id: v.er1, data: rexp, cyc: cyc_cnt});
    end
    if (we) mdl[wreg] = wdat;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    if (reset) begin
      last0 = 32'h0;
      last1 = 32'h0;
    end
    while (sb.size() > 0 && sb[0].cyc < cyc_cnt - 1) begin
      checks++;
      errors++;
      $display("FAIL rsp_missing: no response, expected rs%0d data %h",
               sb[0].id, sb[0].data);
      void'(sb.pop_front());
    end
    if (rs0_valid || rs1_valid) begin
      chk("rsp_single", 32'(rs0_valid & rs1_valid), 32'h0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_spurious: rs0_valid=%b rs1_valid=%b, none expected",
                 rs0_valid, rs1_valid);
      end else begin
        e = sb.pop_front();
        chk("rsp_latency", 32'(cyc_cnt - 1), 32'(e.cyc));
        chk("rsp_port", 32'(rs1_valid), 32'(e.id));
        chk("rsp_data", rs1_valid ? rs1_data : rs0_data, e.data);
        if (e.id) last1 = e.data;
        else      last0 = e.data;
      end
    end
    if (!rs0_valid) chk("rs0_hold", rs0_data, last0);
    if (!rs1_valid) chk("rs1_hold", rs1_data, last1);
  end

  initial begin
    // basic write/read, inc0 pinning, round-robin, forwarding
    vt.push_back(V(0,0,0,0, 1,3,32'hDEADBEEF, 0,0,0, 'b0010));
    vt.push_back(V(1,3,0,0, 0,0,0, 0,0,0, 'b1000));
    vt.push_back(V(0,0,0,0, 0,0,0, 1,0,32'h1234, 'b0001));
    vt.push_back(V(0,0,1,0, 0,0,0, 0,0,0, 'b0100));
    vt.push_back(V(0,0,0,0, 1,2,32'h2222_2222, 0,0,0, 'b0010));
    vt.push_back(V(0,0,0,0, 1,5,32'h5555_5555, 0,0,0, 'b0010));
    vt.push_back(V(0,0,0,0, 1,4,32'h11, 0,0,0, 'b0010));
    vt.push_back(V(1,2,1,5, 0,0,0, 0,0,0, 'b1000));
    vt.push_back(V(1,2,1,5, 0,0,0, 0,0,0, 'b0100));
    vt.push_back(V(1,2,1,5, 0,0,0, 0,0,0, 'b1000));
    vt.push_back(V(1,2,1,5, 0,0,0, 0,0,0, 'b0100));
    vt.push_back(V(1,4,0,0, 1,4,32'hA5A5_A5A5, 0,0,0, 'b1010));
    vt.push_back(V(1,4,0,0, 0,0,0, 0,0,0, 'b1000));
    vt.push_back(V(0,0,1,3, 0,0,0, 0,0,0, 'b0100));
    vt.push_back(V(1,3,0,0, 1,3,32'h3333_3333, 0,0,0, 'b1010));
    vt.push_back(V(0,0,0,0, 0,0,0, 1,1,32'hC0FF_EE01, 'b0001));
    vt.push_back(V(0,0,1,1, 0,0,0, 0,0,0, 'b0100));
    // starvation: w1 wins every fifth cycle, r0 watches reg7
    for (int i = 0; i < 10; i++)
      vt.push_back(V(1,7,0,0, 1,6,32'h600 + 32'(i),
                     1,7,32'h700 + 32'(i), (i % 5 == 4) ? 'b1001 : 'b1010));
    // starve counter clears when w1 drops
    vt.push_back(V(0,0,0,0, 1,6,32'h61, 1,7,32'h71, 'b0010));
    vt.push_back(V(0,0,0,0, 1,6,32'h62, 1,7,32'h72, 'b0010));
    vt.push_back(V(0,0,0,0, 1,6,32'h63, 0,0,0, 'b0010));
    for (int i = 0; i < 4; i++)
      vt.push_back(V(0,0,0,0, 1,6,32'h80 + 32'(i), 1,7,32'h90, 'b0010));
    vt.push_back(V(0,0,0,0, 1,6,32'h85, 1,7,32'h95, 'b0001));
    vt.push_back(V(1,7,0,0, 0,0,0, 0,0,0, 'b1000));
    // pre-reset: rd_ptr -> r1, starve count -> 3
    vt.push_back(V(1,1,1,2, 0,0,0, 0,0,0, 'b1000));
    for (int i = 0; i < 3; i++)
      vt.push_back(V(0,0,0,0, 1,6,32'hA0, 1,7,32'hB0, 'b0010));
    // post-reset: rd_ptr back at r0, w1 needs four fresh losses
    vt2.push_back(V(1,1,1,2, 0,0,0, 0,0,0, 'b1000));
    for (int i = 0; i < 4; i++)
      vt2.push_back(V(0,0,0,0, 1,6,32'hC0, 1,7,32'hD0, 'b0010));
    vt2.push_back(V(0,0,0,0, 1,6,32'hC1, 1,7,32'hD1, 'b0001));
    vt2.push_back(V(1,7,1,6, 0,0,0, 0,0,0, 'b0100));

    idle_inputs();
    mdl_init();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rs0_valid", 32'(rs0_valid), 32'h0);
    chk("rst_rs1_valid", 32'(rs1_valid), 32'h0);
    chk("rst_rs0_data", rs0_data, 32'h0);
    chk("rst_rs1_data", rs1_data, 32'h0);
    chk("rst_rf_a_en", 32'(rf_a_en), 32'h0);
    chk("rst_rf_c_we", 32'(rf_c_we), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vt[i]) apply_vec(vt[i]);

    // grant r1, then reset before its response can appear
    rq1_valid = 1'b1; rq1_reg = 3'd2;
    @(negedge clk);
    chk("pre_rst_rq1_ready", 32'(rq1_ready), 32'h1);
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rs1_valid", 32'(rs1_valid), 32'h0);
    chk("mid_rst_rs1_data", rs1_data, 32'h0);
    chk("mid_rst_rs0_data", rs0_data, 32'h0);
    chk("mid_rst_rf_a_en", 32'(rf_a_en), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    mdl_init();
    @(negedge clk);
    chk("post_rst_rs1_valid", 32'(rs1_valid), 32'h0);
    chk("post_rst_rs0_valid", 32'(rs0_valid), 32'h0);
    @(posedge clk);
    #1;

    foreach (vt2[i]) apply_vec(vt2[i]);

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
